// File: rtl/register_file_sb_pkg.sv
// Shared CPU register-file constants and helpers.
//   REG_ADDR_WIDTH / DATA_WIDTH : default architectural register geometry
//   REG_ZERO                    : hard-wired zero register index
//   idx_to_onehot               : register index -> one-hot select vector
//                                 (also used by the forwarding unit)
package register_file_sb_pkg;

  localparam int REG_ADDR_WIDTH = 5;
  localparam int DATA_WIDTH     = 32;
  localparam logic [REG_ADDR_WIDTH-1:0] REG_ZERO = '0;

  function automatic logic [(2**REG_ADDR_WIDTH)-1:0] idx_to_onehot(
    input logic [REG_ADDR_WIDTH-1:0] idx
  );
    idx_to_onehot      = '0;
    idx_to_onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/register_file_sb_scoreboard.sv
// Busy scoreboard for in-flight long-latency results.
//   clk, rst      : clock, synchronous active-high reset
//   rsv_addr      : issue-stage reservation index (0 = none)
//   wr1_addr      : long-latency writeback index, clears busy (0 = none)
//   lookup_addr   : packed per-read-port indices
//   lookup_busy   : per-port busy flag, masked by a completing wr1
//   any_busy      : registered, at least one busy bit set
//   busy_count    : registered count of busy registers
module regfile_scoreboard
  import register_file_sb_pkg::*;
#(
  parameter int ADDR_WIDTH = REG_ADDR_WIDTH,
  parameter int NUM_READ   = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [ADDR_WIDTH-1:0]            rsv_addr,
  input  logic [ADDR_WIDTH-1:0]            wr1_addr,
  input  logic [NUM_READ*ADDR_WIDTH-1:0]   lookup_addr,
  output logic [NUM_READ-1:0]              lookup_busy,
  output logic                             any_busy,
  output logic [ADDR_WIDTH:0]              busy_count
);

  localparam int NREGS = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(REG_ZERO);

  logic [NREGS-1:0]      busy;
  logic [NREGS-1:0]      busy_next;
  logic [NREGS-1:0]      rsv_hot;
  logic [NREGS-1:0]      clr_hot;
  logic                  do_rsv;
  logic                  do_clr;
  logic                  cnt_inc;
  logic                  cnt_dec;
  logic [ADDR_WIDTH-1:0] look_idx;

  assign do_rsv = (rsv_addr != ZERO_IDX);
  assign do_clr = (wr1_addr != ZERO_IDX);

  always_comb begin
    rsv_hot = do_rsv ? NREGS'(idx_to_onehot(REG_ADDR_WIDTH'(rsv_addr))) : '0;
    clr_hot = do_clr ? NREGS'(idx_to_onehot(REG_ADDR_WIDTH'(wr1_addr))) : '0;
    // Set after clear so a same-index reserve/complete leaves the bit set.
    busy_next    = (busy & ~clr_hot) | rsv_hot;
    busy_next[0] = 1'b0;
    cnt_inc = do_rsv && !busy[rsv_addr];
    // A clear on the index being reserved this cycle is absorbed by the reserve.
    cnt_dec = do_clr && busy[wr1_addr] && (wr1_addr != rsv_addr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy       <= '0;
      busy_count <= '0;
      any_busy   <= 1'b0;
    end else begin
      busy       <= busy_next;
      busy_count <= busy_count + (ADDR_WIDTH+1)'(cnt_inc) - (ADDR_WIDTH+1)'(cnt_dec);
      any_busy   <= (busy_next != '0);
    end
  end

  always_comb begin
    lookup_busy = '0;
    look_idx    = '0;
    for (int unsigned k = 0; k < NUM_READ; k++) begin
      look_idx       = lookup_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
      lookup_busy[k] = busy[look_idx] && (wr1_addr != look_idx);
    end
  end

endmodule

// File: rtl/register_file_sb.sv
// General-purpose register file with two write ports, write-to-read bypass
// and a busy scoreboard for long-latency results.
//   clk, rst            : clock, synchronous active-high reset
//   read_addr/read_data : packed multi-port combinational reads
//   read_busy           : per-port "value not yet valid" flag
//   wr0_addr/wr0_data   : fast (ALU) writeback, 0 = no write
//   wr1_addr/wr1_data   : long-latency writeback, clears busy, 0 = no write
//   rsv_addr            : reservation of a destination, 0 = none
//   any_busy/busy_count : registered scoreboard summary
//   debug_out           : stored value of register DEBUG_REG, no bypass
module register_file_sb
  import register_file_sb_pkg::*;
#(
  parameter int DATA_WIDTH = register_file_sb_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = REG_ADDR_WIDTH,
  parameter int NUM_READ   = 2,
  parameter int DEBUG_REG  = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_READ*ADDR_WIDTH-1:0]  read_addr,
  output logic [NUM_READ*DATA_WIDTH-1:0]  read_data,
  output logic [NUM_READ-1:0]             read_busy,
  input  logic [ADDR_WIDTH-1:0]           wr0_addr,
  input  logic [DATA_WIDTH-1:0]           wr0_data,
  input  logic [ADDR_WIDTH-1:0]           wr1_addr,
  input  logic [DATA_WIDTH-1:0]           wr1_data,
  input  logic [ADDR_WIDTH-1:0]           rsv_addr,
  output logic                            any_busy,
  output logic [ADDR_WIDTH:0]             busy_count,
  output logic [DATA_WIDTH-1:0]           debug_out
);

  localparam int NREGS = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(REG_ZERO);

  logic [DATA_WIDTH-1:0] mem [NREGS];
  logic [ADDR_WIDTH-1:0] rd_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        mem[i] <= '0;
      end
    end else begin
      // wr0 is applied last so it owns the final value on an index collision.
      if (wr1_addr != ZERO_IDX) mem[wr1_addr] <= wr1_data;
      if (wr0_addr != ZERO_IDX) mem[wr0_addr] <= wr0_data;
    end
  end

  always_comb begin
    read_data = '0;
    rd_idx    = '0;
    for (int unsigned k = 0; k < NUM_READ; k++) begin
      rd_idx = read_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
      if (rd_idx == ZERO_IDX)
        read_data[k*DATA_WIDTH +: DATA_WIDTH] = '0;
      else if (wr0_addr == rd_idx)
        read_data[k*DATA_WIDTH +: DATA_WIDTH] = wr0_data;
      else if (wr1_addr == rd_idx)
        read_data[k*DATA_WIDTH +: DATA_WIDTH] = wr1_data;
      else
        read_data[k*DATA_WIDTH +: DATA_WIDTH] = mem[rd_idx];
    end
  end

  assign debug_out = mem[DEBUG_REG];

  regfile_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_READ   (NUM_READ)
  ) u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .rsv_addr    (rsv_addr),
    .wr1_addr    (wr1_addr),
    .lookup_addr (read_addr),
    .lookup_busy (read_busy),
    .any_busy    (any_busy),
    .busy_count  (busy_count)
  );

endmodule

// File: tb/tb_register_file_sb.sv
module tb_register_file_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  read_addr;
  logic [63:0] read_data;
  logic [1:0]  read_busy;
  logic [4:0]  wr0_addr, wr1_addr, rsv_addr;
  logic [31:0] wr0_data, wr1_data;
  logic        any_busy;
  logic [5:0]  busy_count;
  logic [31:0] debug_out;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  register_file_sb #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (5),
    .NUM_READ   (2),
    .DEBUG_REG  (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .read_addr  (read_addr),
    .read_data  (read_data),
    .read_busy  (read_busy),
    .wr0_addr   (wr0_addr),
    .wr0_data   (wr0_data),
    .wr1_addr   (wr1_addr),
    .wr1_data   (wr1_data),
    .rsv_addr   (rsv_addr),
    .any_busy   (any_busy),
    .busy_count (busy_count),
    .debug_out  (debug_out)
  );

  typedef struct {
    logic        rst;
    logic [4:0]  w0a;
    logic [31:0] w0d;
    logic [4:0]  w1a;
    logic [31:0] w1d;
    logic [4:0]  rsv;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] e0;
    logic [31:0] e1;
    logic [1:0]  eb;
    logic [5:0]  ec;
    logic        ea;
    logic [31:0] edbg;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    input logic r, input logic [4:0] w0a, input logic [31:0] w0d,
    input logic [4:0] w1a, input logic [31:0] w1d, input logic [4:0] rsv,
    input logic [4:0] ra0, input logic [4:0] ra1,
    input logic [31:0] e0, input logic [31:0] e1, input logic [1:0] eb,
    input logic [5:0] ec, input logic ea, input logic [31:0] edbg);
    vec_t v;
    v.rst = r;  v.w0a = w0a; v.w0d = w0d; v.w1a = w1a; v.w1d = w1d;
    v.rsv = rsv; v.ra0 = ra0; v.ra1 = ra1; v.e0 = e0; v.e1 = e1;
    v.eb = eb;  v.ec = ec;   v.ea = ea;   v.edbg = edbg;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(input logic r, input logic [4:0] w0a, input logic [31:0] w0d,
                       input logic [4:0] w1a, input logic [31:0] w1d,
                       input logic [4:0] rsv, input logic [4:0] ra0, input logic [4:0] ra1);
    rst = r; wr0_addr = w0a; wr0_data = w0d; wr1_addr = w1a; wr1_data = w1d;
    rsv_addr = rsv; read_addr = {ra1, ra0};
  endtask

  initial begin
    drive(1'b1, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    drive(1'b0, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 5'd5, 5'd0);
    #2;
    check("rst_rd0", read_data[31:0], 32'h0);
    check("rst_busy", {30'd0, read_busy}, 32'h0);
    check("rst_cnt", {26'd0, busy_count}, 32'h0);
    check("rst_any", {31'd0, any_busy}, 32'h0);
    check("rst_dbg", debug_out, 32'h0);

    //           rst w0a   w0d           w1a   w1d         rsv    ra0    ra1    e0            e1            eb     ec    ea    edbg
    tbl.push_back(mk(0, 5'd5, 32'h1234,     5'd0, 32'h0,    5'd0,  5'd5,  5'd5,  32'h1234,     32'h1234,     2'b00, 6'd0, 1'b0, 32'h0));
    tbl.push_back(mk(1, 5'd0, 32'h0,        5'd0, 32'h0,    5'd0,  5'd5,  5'd0,  32'h1234,     32'h0,        2'b00, 6'd0, 1'b0, 32'h0));
    tbl.push_back(mk(0, 5'd0, 32'h0,        5'd0, 32'h0,    5'd0,  5'd5,  5'd0,  32'h0,        32'h0,        2'b00, 6'd0, 1'b0, 32'h0));
    tbl.push_back(mk(0, 5'd3, 32'hDEADBEEF, 5'd0, 32'h0,    5'd0,  5'd3,  5'd0,  32'hDEADBEEF, 32'h0,        2'b00, 6'd0, 1'b0, 32'h0));
    tbl.push_back(mk(0, 5'd0, 32'hFFFFFFFF, 5'd0, 32'h0,    5'd0,  5'd3,  5'd0,  32'hDEADBEEF, 32'h0,        2'b00, 6'd0, 1'b0, 32'h0));
    tbl.push_back(mk(0, 5'd7, 32'hA,        5'd7, 32'hB,    5'd0,  5'd7,  5'd0,  32'hA,        32'h0,        2'b00, 6'd0, 1'b0, 32'h0));
    tbl.push_back(mk(0, 5'd0, 32'h0,        5'd0, 32'h0,    5'd0,  5'd7,  5'd3,  32'hA,        32'hDEADBEEF, 2'b00, 6'd0, 1'b0, 32'h0));
    tbl.push_back(mk(0, 5'd1, 32'hCAFE,     5'd0, 32'h0,    5'd0,  5'd1,  5'd1,  32'hCAFE,     32'hCAFE,     2'b00, 6'd0, 1'b0, 32'h0));
    tbl.push_back(mk(0, 5'd0, 32'h0,        5'd0, 32'h0,    5'd0,  5'd1,  5'd0,  32'hCAFE,     32'h0,        2'b00, 6'd0, 1'b0, 32'hCAFE));
    tbl.push_back(mk(0, 5'd0, 32'h0,        5'd0, 32'h0,    5'd9,  5'd9,  5'd9,  32'h0,        32'h0,        2'b00, 6'd0, 1'b0, 32'hCAFE));
    tbl.push_back(mk(0, 5'd0, 32'h0,        5'd0, 32'h0,    5'd0,  5'd9,  5'd9,  32'h0,        32'h0,        2'b11, 6'd1, 1'b1, 32'hCAFE));
    tbl.push_back(mk(0, 5'd0, 32'h0,        5'd9, 32'h55,   5'd0,  5'd9,  5'd9,  32'h55,       32'h55,       2'b00, 6'd1, 1'b1, 32'hCAFE));
    tbl.push_back(mk(0, 5'd0, 32'h0,        5'd0, 32'h0,    5'd0,  5'd9,  5'd0,  32'h55,       32'h0,        2'b00, 6'd0, 1'b0, 32'hCAFE));
    tbl.push_back(mk(0, 5'd0, 32'h0,        5'd0, 32'h0,    5'd4,  5'd4,  5'd0,  32'h0,        32'h0,        2'b00, 6'd0, 1'b0, 32'hCAFE));
    tbl.push_back(mk(0, 5'd0, 32'h0,        5'd4, 32'h44,   5'd4,  5'd4,  5'd4,  32'h44,       32'h44,       2'b00, 6'd1, 1'b1, 32'hCAFE));
    tbl.push_back(mk(0, 5'd0, 32'h0,        5'd0, 32'h0,    5'd0,  5'd4,  5'd4,  32'h44,       32'h44,       2'b11, 6'd1, 1'b1, 32'hCAFE));
    tbl.push_back(mk(0, 5'd4, 32'h99,       5'd0, 32'h0,    5'd0,  5'd4,  5'd4,  32'h99,       32'h99,       2'b11, 6'd1, 1'b1, 32'hCAFE));
    tbl.push_back(mk(0, 5'd0, 32'h0,        5'd0, 32'h0,    5'd0,  5'd4,  5'd4,  32'h99,       32'h99,       2'b11, 6'd1, 1'b1, 32'hCAFE));
    tbl.push_back(mk(0, 5'd0, 32'h0,        5'd0, 32'h0,    5'd2,  5'd4,  5'd2,  32'h99,       32'h0,        2'b01, 6'd1, 1'b1, 32'hCAFE));
    tbl.push_back(mk(0, 5'd0, 32'h0,        5'd4, 32'h77,   5'd6,  5'd2,  5'd4,  32'h0,        32'h77,       2'b01, 6'd2, 1'b1, 32'hCAFE));
    tbl.push_back(mk(0, 5'd0, 32'h0,        5'd0, 32'h0,    5'd10, 5'd6,  5'd4,  32'h0,        32'h77,       2'b01, 6'd2, 1'b1, 32'hCAFE));
    tbl.push_back(mk(0, 5'd0, 32'h0,        5'd12, 32'h12,  5'd0,  5'd10, 5'd2,  32'h0,        32'h0,        2'b11, 6'd3, 1'b1, 32'hCAFE));
    tbl.push_back(mk(0, 5'd0, 32'h0,        5'd0, 32'h0,    5'd2,  5'd12, 5'd0,  32'h12,       32'h0,        2'b00, 6'd3, 1'b1, 32'hCAFE));
    tbl.push_back(mk(1, 5'd0, 32'h0,        5'd2, 32'h2222, 5'd11, 5'd2,  5'd6,  32'h2222,     32'h0,        2'b10, 6'd3, 1'b1, 32'hCAFE));
    tbl.push_back(mk(0, 5'd0, 32'h0,        5'd0, 32'h0,    5'd0,  5'd2,  5'd6,  32'h0,        32'h0,        2'b00, 6'd0, 1'b0, 32'h0));
    tbl.push_back(mk(0, 5'd0, 32'h0,        5'd0, 32'h0,    5'd0,  5'd7,  5'd11, 32'h0,        32'h0,        2'b00, 6'd0, 1'b0, 32'h0));

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].rst, tbl[i].w0a, tbl[i].w0d, tbl[i].w1a, tbl[i].w1d,
            tbl[i].rsv, tbl[i].ra0, tbl[i].ra1);
      #2;
      check($sformatf("v%0d_rd0", i), read_data[31:0], tbl[i].e0);
      check($sformatf("v%0d_rd1", i), read_data[63:32], tbl[i].e1);
      check($sformatf("v%0d_busy", i), {30'd0, read_busy}, {30'd0, tbl[i].eb});
      check($sformatf("v%0d_cnt", i), {26'd0, busy_count}, {26'd0, tbl[i].ec});
      check($sformatf("v%0d_any", i), {31'd0, any_busy}, {31'd0, tbl[i].ea});
      check($sformatf("v%0d_dbg", i), debug_out, tbl[i].edbg);
    end

    // Fill the scoreboard completely, then drain it through wr1.
    for (int i = 1; i < 32; i++) begin
      @(negedge clk);
      drive(1'b0, 5'd0, 32'h0, 5'd0, 32'h0, 5'(i), 5'd0, 5'd0);
    end
    @(negedge clk);
    drive(1'b0, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 5'd31, 5'd1);
    #2;
    check("full_cnt", {26'd0, busy_count}, 32'd31);
    check("full_any", {31'd0, any_busy}, 32'd1);
    check("full_busy", {30'd0, read_busy}, 32'd3);
    for (int i = 1; i < 32; i++) begin
      @(negedge clk);
      drive(1'b0, 5'd0, 32'h0, 5'(i), 32'(i * 3), 5'd0, 5'd0, 5'd0);
    end
    @(negedge clk);
    drive(1'b0, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 5'd31, 5'd1);
    #2;
    check("drain_cnt", {26'd0, busy_count}, 32'd0);
    check("drain_any", {31'd0, any_busy}, 32'd0);
    check("drain_busy", {30'd0, read_busy}, 32'd0);
    check("drain_rd31", read_data[31:0], 32'd93);
    check("drain_dbg", debug_out, 32'd3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule

// File: doc/register_file_sb.md
Name: register_file_sb

Overview:
- Next-generation general-purpose register file for the CPU datapath.
- Parametrised in data width, address width and read-port count.
- Adds a second write port for the long-latency writeback path (loads, multiply/divide).
- Adds same-cycle write-to-read bypass and a per-register busy scoreboard, so the issue stage can detect RAW/WAW hazards on in-flight long-latency results.
- Sits between decode/issue (reads, reservations) and the writeback stages (writes).

Parameters:
- DATA_WIDTH, 32, width of each register.
- ADDR_WIDTH, 5, register index width; the file holds 2**ADDR_WIDTH registers.
- NUM_READ, 2, number of independent read ports.
- DEBUG_REG, 1, index of the register mirrored on debug_out.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous active-high reset.
- read_addr  in  NUM_READ*ADDR_WIDTH  packed read indices; port k occupies bits [k*ADDR_WIDTH +: ADDR_WIDTH].
- read_data  out  NUM_READ*DATA_WIDTH  packed read data, same packing.
- read_busy  out  NUM_READ  per-port flag: the addressed register is reserved and its value is not valid.
- wr0_addr  in  ADDR_WIDTH  fast writeback index (ALU results); 0 means no write.
- wr0_data  in  DATA_WIDTH  fast writeback data.
- wr1_addr  in  ADDR_WIDTH  long-latency writeback index; 0 means no write.
- wr1_data  in  DATA_WIDTH  long-latency writeback data.
- rsv_addr  in  ADDR_WIDTH  issue-stage reservation index; 0 means no reservation.
- any_busy  out  1  at least one busy bit is set.
- busy_count  out  ADDR_WIDTH+1  number of registers currently busy.
- debug_out  out  DATA_WIDTH  current stored value of register DEBUG_REG, with no bypass.

Behaviour:
- Storage:
  - 2**ADDR_WIDTH registers plus a busy bit per register.
  - Register 0 reads as 0, is never written and is never busy.
- Reset (rst high at a posedge):
  - All registers and busy bits clear; pending writes and reservations that cycle are discarded.
  - After reset: read_data 0 for every port, read_busy 0, any_busy 0, busy_count 0, debug_out 0.
  - Reset mid-operation is legal and aborts all in-flight reservations.
- Write, at posedge when not in reset:
  - wr0_addr!=0 writes mem[wr0_addr]<=wr0_data.
  - wr1_addr!=0 writes mem[wr1_addr]<=wr1_data.
  - Both ports target the same nonzero index: wr0 wins, since the younger instruction owns the final value.
- Busy update, at posedge:
  - wr1 to a nonzero index clears busy[wr1_addr].
  - rsv_addr!=0 sets busy[rsv_addr].
  - Reserve and clear of the same index in one cycle: reserve wins, so busy stays 1.
  - wr0 never changes busy bits.
- Read, combinational, zero latency, per port k with a = that port's index:
  - a==0 gives data 0, busy 0.
  - Else if wr0_addr==a, data is wr0_data (bypass).
  - Else if wr1_addr==a, data is wr1_data (bypass).
  - Else data is mem[a].
  - read_busy[k] = busy[a] AND NOT (wr1_addr==a). A completing long-latency result is usable in the same cycle.
  - rsv_addr in the current cycle does not affect read_busy until the next cycle.
- busy_count and any_busy:
  - Registered; they reflect the busy vector after each posedge.
  - busy_count is maintained incrementally: +1 on reserving a non-busy register, −1 on clearing a busy one.
  - Reserve and clear of distinct registers in one cycle: net 0.
  - Reserving an already-busy register: +0.
  - Clearing a non-busy register: −0; this is legal and ignored.
- Illegal but defined: wr0 to a busy register writes the data and leaves busy set.
- The issue stage must stall on read_busy; this block does no stall generation.

Decomposition:
- Shared cpu package constants: REG_ADDR_WIDTH=5, DATA_WIDTH=32, REG_ZERO=0.
- Shared cpu package function: index-to-one-hot decode, reused by the forwarding unit.
- One sub-module, regfile_scoreboard:
  - Owns the busy vector, busy_count and any_busy.
  - Inputs: clk, rst, rsv_addr, wr1_addr, NUM_READ lookup indices.
  - Keeps hazard bookkeeping separate from the storage array.

Test Plan:
- Reset: rst high for 1 cycle after writing r5=0x1234 → read r5 gives 0, busy_count 0, debug_out 0.
- Write/read: wr0 r3=0xDEADBEEF, then read r3 next cycle → 0xDEADBEEF; wr0 to r0=0xFFFFFFFF → r0 reads 0.
- Bypass and priority: same cycle wr0 r7=0xA, wr1 r7=0xB, port0 reads r7 → 0xA combinationally; next cycle r7 stored 0xA.
- Scoreboard lifecycle:
  - rsv r9 → next cycle read_busy=1, busy_count 1, any_busy 1.
  - wr1 r9=0x55 with port1 reading r9 → read_busy 0, data 0x55 that cycle; busy_count 0 after the edge.
- Simultaneous reserve/clear: busy r4 set; one cycle with rsv r4 and wr1 r4 → r4 still busy, busy_count unchanged at 1.
- Reset mid-operation: r2, r6, r10 reserved (busy_count 3), rst with wr1 r2 same cycle → all busy 0, busy_count 0, r2 reads 0.
